// File: rtl/uart_baud_controller_if.sv
// Request/status bundle between the baud controller and its host logic.
// master = host side (buttons, decoder status, raw RX), slave = controller.
interface uart_baud_controller_if;
    logic        i_Fast_Pulse;
    logic        i_Slow_Pulse;
    logic        i_Halve_Pulse;
    logic        i_Double_Pulse;
    logic        i_Autobaud_Pulse;
    logic        i_Rx_Busy;
    logic        i_UART_RX;
    logic [19:0] o_Period;
    logic        o_Period_Valid;
    logic        o_Busy;
    logic        o_Autobaud_Fail;

    modport master (
        output i_Fast_Pulse, i_Slow_Pulse, i_Halve_Pulse, i_Double_Pulse,
               i_Autobaud_Pulse, i_Rx_Busy, i_UART_RX,
        input  o_Period, o_Period_Valid, o_Busy, o_Autobaud_Fail
    );

    modport slave (
        input  i_Fast_Pulse, i_Slow_Pulse, i_Halve_Pulse, i_Double_Pulse,
               i_Autobaud_Pulse, i_Rx_Busy, i_UART_RX,
        output o_Period, o_Period_Valid, o_Busy, o_Autobaud_Fail
    );
endinterface

// File: rtl/uart_baud_controller.sv
// Baud-period sequencer for the variable-rate UART receiver.
// Arbitrates preset/halve/double requests, defers the change until the
// decoder is between frames, then publishes a clamped clocks-per-bit value.
// Optional auto-baud measurement is built when UART_BAUD_CTRL_AUTOBAUD_EN
// is defined; otherwise i_Autobaud_Pulse/i_UART_RX are ignored.
module uart_baud_controller #(
    parameter int unsigned FAST_PERIOD = 217,
    parameter int unsigned SLOW_PERIOD = 2604,
    parameter int unsigned MIN_PERIOD  = 16,
    parameter int unsigned MAX_PERIOD  = 208333,
    parameter int unsigned ARM_TIMEOUT = 50000000
) (
    input logic                   i_Clk,
    input logic                   i_Reset,
    uart_baud_controller_if.slave bus
);
    localparam int unsigned PW = 20;
    localparam int unsigned DW = PW + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_QUIET = 3'd1,
        APPLY      = 3'd2,
        ARM        = 3'd3,
        MEASURE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          fail_q, fail_d;

    logic [PW-1:0] halve_val;
    logic [DW-1:0] double_raw;
    logic [PW-1:0] double_val;

`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
    localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);
    localparam int unsigned CNT_W = (ARM_W > DW) ? ARM_W : DW;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_fall;

    assign rx_fall = rx_prev_q & ~rx_sync_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.i_Autobaud_Pulse, bus.i_UART_RX,
                         32'(ARM_TIMEOUT) == 32'd0};
`endif

    // Clamped candidates derived from the currently published period.
    assign halve_val  = ((period_q >> 1) < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : (period_q >> 1);
    assign double_raw = {period_q, 1'b0};
    assign double_val = (double_raw > DW'(MAX_PERIOD)) ? PW'(MAX_PERIOD) : double_raw[PW-1:0];

    // State, outputs, synchroniser and measurement counter registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            period_q  <= PW'(FAST_PERIOD);
            pending_q <= PW'(FAST_PERIOD);
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            fail_q    <= 1'b0;
`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            fail_q    <= fail_d;
`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
            rx_meta_q <= bus.i_UART_RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state, arbitration and registered-output logic.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        pending_d = pending_q;
        valid_d   = 1'b0;
        fail_d    = 1'b0;
`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_Fast_Pulse) begin
                    pending_d = PW'(FAST_PERIOD);
                    state_d   = WAIT_QUIET;
                end else if (bus.i_Slow_Pulse) begin
                    pending_d = PW'(SLOW_PERIOD);
                    state_d   = WAIT_QUIET;
                end else if (bus.i_Halve_Pulse) begin
                    pending_d = halve_val;
                    state_d   = WAIT_QUIET;
                end else if (bus.i_Double_Pulse) begin
                    pending_d = double_val;
                    state_d   = WAIT_QUIET;
                end
`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
                else if (bus.i_Autobaud_Pulse) begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
`endif
            end
            WAIT_QUIET: begin
                if (!bus.i_Rx_Busy) state_d = APPLY;
            end
            APPLY: begin
                period_d = pending_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
            ARM: begin
                if (rx_fall) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(ARM_TIMEOUT)) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!rx_sync_q) begin
                    // Next increment would pass MAX_PERIOD: give up without waiting for RX.
                    if (cnt_q >= CNT_W'(MAX_PERIOD)) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q >= CNT_W'(MIN_PERIOD) && cnt_q <= CNT_W'(MAX_PERIOD)) begin
                    pending_d = PW'(cnt_q);
                    state_d   = WAIT_QUIET;
                end else begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.o_Period        = period_q;
    assign bus.o_Period_Valid  = valid_q;
    assign bus.o_Busy          = busy_q;
    assign bus.o_Autobaud_Fail = fail_q;
endmodule

// File: tb/tb_uart_baud_controller.sv
// Directed self-checking bench for uart_baud_controller.
// Auto-baud sequences are included when UART_BAUD_CTRL_AUTOBAUD_EN is defined.
module tb_uart_baud_controller;
    localparam int unsigned TB_ARM_TIMEOUT = 3000;
    localparam int unsigned BIT_CLKS       = 2604;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_baud_controller_if bus();

    uart_baud_controller #(
        .FAST_PERIOD(217),
        .SLOW_PERIOD(2604),
        .MIN_PERIOD (16),
        .MAX_PERIOD (208333),
        .ARM_TIMEOUT(TB_ARM_TIMEOUT)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus.slave)
    );

    int tests  = 0;
    int fails  = 0;
    int valid_cnt = 0;
    int fail_cnt  = 0;

    // Count strobes as seen just before each edge updates them.
    always @(posedge clk) begin
        if (bus.o_Period_Valid === 1'b1) valid_cnt++;
        if (bus.o_Autobaud_Fail === 1'b1) fail_cnt++;
    end

    typedef struct {
        logic        fast;
        logic        slow;
        logic        halve;
        logic        dbl;
        logic        autob;
        int unsigned exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_pulses();
        bus.i_Fast_Pulse     = 1'b0;
        bus.i_Slow_Pulse     = 1'b0;
        bus.i_Halve_Pulse    = 1'b0;
        bus.i_Double_Pulse   = 1'b0;
        bus.i_Autobaud_Pulse = 1'b0;
    endtask

    // One request with i_Rx_Busy low; checks the exact two-cycle latency.
    task automatic apply_req(input string nm, input logic f, input logic s, input logic h,
                             input logic d, input logic a, input int unsigned exp);
        @(negedge clk);
        valid_cnt = 0;
        bus.i_Fast_Pulse     = f;
        bus.i_Slow_Pulse     = s;
        bus.i_Halve_Pulse    = h;
        bus.i_Double_Pulse   = d;
        bus.i_Autobaud_Pulse = a;
        @(negedge clk);
        clear_pulses();
        check({nm, "_busy_wq"}, bus.o_Busy, 1);
        @(negedge clk);
        check({nm, "_valid_apply"}, bus.o_Period_Valid, 0);
        @(negedge clk);
        check({nm, "_period"}, bus.o_Period, exp);
        check({nm, "_valid"}, bus.o_Period_Valid, 1);
        check({nm, "_busy_idle"}, bus.o_Busy, 0);
        @(negedge clk);
        check({nm, "_valid_cnt"}, valid_cnt, 1);
    endtask

`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
    // Serial byte, LSB first, BIT_CLKS clocks per bit.
    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.i_UART_RX = frame[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        bus.i_UART_RX = 1'b1;
    endtask

    task automatic pulse_autobaud();
        @(negedge clk);
        bus.i_Autobaud_Pulse = 1'b1;
        @(negedge clk);
        bus.i_Autobaud_Pulse = 1'b0;
    endtask
`endif

    initial begin
        int unsigned meas;
        logic        busy_ok;

        clear_pulses();
        bus.i_Rx_Busy = 1'b0;
        bus.i_UART_RX = 1'b1;

        vecs[0]  = '{0, 1, 0, 0, 0, 2604};
        vecs[1]  = '{0, 0, 0, 1, 0, 5208};
        vecs[2]  = '{0, 0, 0, 1, 0, 10416};
        vecs[3]  = '{0, 0, 0, 1, 0, 20832};
        vecs[4]  = '{0, 0, 0, 1, 0, 41664};
        vecs[5]  = '{0, 0, 0, 1, 0, 83328};
        vecs[6]  = '{0, 0, 0, 1, 0, 166656};
        vecs[7]  = '{0, 0, 0, 1, 0, 208333};
        vecs[8]  = '{0, 0, 0, 1, 0, 208333};
        vecs[9]  = '{1, 0, 0, 0, 0, 217};
        vecs[10] = '{0, 0, 1, 0, 0, 108};
        vecs[11] = '{0, 0, 1, 0, 0, 54};
        vecs[12] = '{0, 0, 1, 0, 0, 27};
        vecs[13] = '{0, 0, 1, 0, 0, 16};
        vecs[14] = '{0, 0, 1, 0, 0, 16};
        vecs[15] = '{0, 1, 0, 0, 0, 2604};
        vecs[16] = '{1, 0, 0, 1, 0, 217};
        vecs[17] = '{0, 1, 1, 0, 0, 2604};
        vecs[18] = '{0, 0, 1, 1, 1, 1302};
        vecs[19] = '{1, 0, 0, 0, 0, 217};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_period", bus.o_Period, 217);
        check("rst_busy", bus.o_Busy, 0);
        check("rst_valid", bus.o_Period_Valid, 0);
        check("rst_fail", bus.o_Autobaud_Fail, 0);
        rst = 1'b0;
        valid_cnt = 0;
        repeat (10) @(negedge clk);
        check("idle_period", bus.o_Period, 217);
        check("idle_busy", bus.o_Busy, 0);
        check("idle_valid_cnt", valid_cnt, 0);

        // Table-driven requests
        for (int i = 0; i < 20; i++)
            apply_req($sformatf("v%0d", i), vecs[i].fast, vecs[i].slow, vecs[i].halve,
                      vecs[i].dbl, vecs[i].autob, vecs[i].exp);

        // Double deferred by a 40-cycle frame; Halve during the wait is dropped
        @(negedge clk);
        valid_cnt = 0;
        bus.i_Rx_Busy = 1'b1;
        bus.i_Double_Pulse = 1'b1;
        @(negedge clk);
        bus.i_Double_Pulse = 1'b0;
        busy_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.i_Halve_Pulse = (c == 20);
            if (bus.o_Busy !== 1'b1 || bus.o_Period !== 20'd217) busy_ok = 1'b0;
            @(negedge clk);
        end
        bus.i_Halve_Pulse = 1'b0;
        check("defer_busy_held", busy_ok, 1);
        check("defer_no_valid", valid_cnt, 0);
        bus.i_Rx_Busy = 1'b0;
        @(negedge clk);
        check("defer_apply_busy", bus.o_Busy, 1);
        @(negedge clk);
        check("defer_period", bus.o_Period, 434);
        check("defer_valid", bus.o_Period_Valid, 1);
        repeat (5) @(negedge clk);
        check("defer_halve_dropped", bus.o_Period, 434);
        check("defer_valid_cnt", valid_cnt, 1);
        check("defer_busy_end", bus.o_Busy, 0);

        // Reset mid-operation aborts the pending request
        bus.i_Rx_Busy = 1'b1;
        bus.i_Slow_Pulse = 1'b1;
        @(negedge clk);
        bus.i_Slow_Pulse = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", bus.o_Busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.o_Busy, 0);
        check("midrst_period", bus.o_Period, 217);
        @(negedge clk);
        rst = 1'b0;
        bus.i_Rx_Busy = 1'b0;
        valid_cnt = 0;
        repeat (5) @(negedge clk);
        check("midrst_no_apply", bus.o_Period, 217);
        check("midrst_valid_cnt", valid_cnt, 0);

        // Reset and pulse together: reset wins
        rst = 1'b1;
        bus.i_Slow_Pulse = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_Slow_Pulse = 1'b0;
        valid_cnt = 0;
        repeat (4) @(negedge clk);
        check("rstpulse_period", bus.o_Period, 217);
        check("rstpulse_busy", bus.o_Busy, 0);
        check("rstpulse_valid_cnt", valid_cnt, 0);

`ifdef UART_BAUD_CTRL_AUTOBAUD_EN
        // Auto-baud on 0x55 at 9600 baud
        valid_cnt = 0;
        fail_cnt  = 0;
        pulse_autobaud();
        check("ab_busy_arm", bus.o_Busy, 1);
        repeat (20) @(negedge clk);
        send_byte(8'h55);
        repeat (20) @(negedge clk);
        meas = bus.o_Period;
        check("ab_period_range", (meas >= 2602 && meas <= 2606) ? 1 : 0, 1);
        check("ab_valid_cnt", valid_cnt, 1);
        check("ab_fail_cnt", fail_cnt, 0);
        check("ab_busy_end", bus.o_Busy, 0);

        apply_req("ab_fast", 1, 0, 0, 0, 0, 217);

        // 10-clock glitch measures below MIN_PERIOD
        valid_cnt = 0;
        fail_cnt  = 0;
        pulse_autobaud();
        repeat (10) @(negedge clk);
        bus.i_UART_RX = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_UART_RX = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_fail_cnt", fail_cnt, 1);
        check("glitch_period", bus.o_Period, 217);
        check("glitch_valid_cnt", valid_cnt, 0);
        check("glitch_busy", bus.o_Busy, 0);

        // No start edge within the arm timeout
        fail_cnt = 0;
        pulse_autobaud();
        repeat (TB_ARM_TIMEOUT - 50) @(negedge clk);
        check("tmo_still_armed", bus.o_Busy, 1);
        check("tmo_no_early_fail", fail_cnt, 0);
        repeat (100) @(negedge clk);
        check("tmo_fail_cnt", fail_cnt, 1);
        check("tmo_period", bus.o_Period, 217);
        check("tmo_busy", bus.o_Busy, 0);
        check("tmo_valid_cnt", valid_cnt, 0);
`else
        // Auto-baud request is ignored in this build
        valid_cnt = 0;
        fail_cnt  = 0;
        @(negedge clk);
        bus.i_Autobaud_Pulse = 1'b1;
        bus.i_UART_RX = 1'b0;
        @(negedge clk);
        bus.i_Autobaud_Pulse = 1'b0;
        check("noab_busy", bus.o_Busy, 0);
        repeat (10) @(negedge clk);
        bus.i_UART_RX = 1'b1;
        repeat (5) @(negedge clk);
        check("noab_period", bus.o_Period, 217);
        check("noab_valid_cnt", valid_cnt, 0);
        check("noab_fail_cnt", fail_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
